// File: rtl/arb_mux_pkg.sv
// Shared definitions for the arb_mux flow-controlled merge point:
// arbitration mode encodings and the select-width helper.
package mux_pkg;

    localparam logic MODE_FIXED       = 1'b0;
    localparam logic MODE_ROUND_ROBIN = 1'b1;

    // At least one select bit, even for a two-channel merge.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arb_mux_if.sv
// Handshake bundle between N producers, the arb_mux merge point and its consumer.
// The slave modport is the arb_mux view; master is the producer/consumer side.
interface arb_mux_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8
);
    import mux_pkg::*;

    localparam int SEL_W = sel_width(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic                      mode;
    logic [SEL_W-1:0]          slct;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_valid;
    logic                      out_ready;

    modport slave (
        input  in_data, in_valid, mode, slct, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );

    modport master (
        output in_data, in_valid, mode, slct, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

endinterface

// File: rtl/arb_mux_rr_arbiter.sv
// Wrap-around priority scan: starting at ptr, grant the first requesting
// channel. Produces a one-hot grant plus its encoded index.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int SEL_W    = sel_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    ptr,
    input  logic                enable,
    output logic [CHANNELS-1:0] grant,
    output logic [SEL_W-1:0]    idx
);

    // One extra bit so ptr + offset never overflows before the modulo wrap.
    logic [SEL_W:0] cand;
    logic           found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cand = {1'b0, ptr} + (SEL_W+1)'(i);
            if (cand >= (SEL_W+1)'(CHANNELS)) begin
                cand = cand - (SEL_W+1)'(CHANNELS);
            end
            if (enable && !found && req[cand[SEL_W-1:0]]) begin
                grant[cand[SEL_W-1:0]] = 1'b1;
                idx                    = cand[SEL_W-1:0];
                found                  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_mux.sv
// N-channel valid/ready merge with FIXED or ROUND_ROBIN arbitration and a
// single registered output entry; out_ready passes straight through to in_ready.
module arb_mux
    import mux_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = sel_width(CHANNELS)
) (
    input logic      clk,
    input logic      rst_n,
    arb_mux_if.slave bus
);

    logic [CHANNELS-1:0] fixed_grant;
    logic [CHANNELS-1:0] rr_grant;
    logic [CHANNELS-1:0] grant;
    logic [SEL_W-1:0]    rr_idx;
    logic [SEL_W-1:0]    grant_idx;
    logic [WIDTH-1:0]    sel_data;
    logic                rr_mode;
    logic                free;
    logic                push;

    logic                out_valid_q, out_valid_d;
    logic [WIDTH-1:0]    out_data_q,  out_data_d;
    logic [SEL_W-1:0]    out_chan_q,  out_chan_d;
    logic [SEL_W-1:0]    ptr_q,       ptr_d;

    assign rr_mode = (bus.mode == MODE_ROUND_ROBIN);

    // Out-of-range selects (possible when CHANNELS is not a power of two) grant nothing.
    always_comb begin
        fixed_grant = '0;
        if ({1'b0, bus.slct} < (SEL_W+1)'(CHANNELS)) begin
            fixed_grant[bus.slct] = bus.in_valid[bus.slct];
        end
    end

    rr_arbiter #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_rr_arbiter (
        .req    (bus.in_valid),
        .ptr    (ptr_q),
        .enable (rr_mode),
        .grant  (rr_grant),
        .idx    (rr_idx)
    );

    always_comb begin
        grant     = rr_mode ? rr_grant : fixed_grant;
        grant_idx = rr_mode ? rr_idx   : bus.slct;
        sel_data  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant[i]) begin
                sel_data = bus.in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // The entry is free when empty or being popped this cycle; nothing is accepted in reset.
    assign free         = !out_valid_q || bus.out_ready;
    assign push         = free && rst_n && (|grant);
    assign bus.in_ready = grant & {CHANNELS{free && rst_n}};

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        if (free) begin
            out_valid_d = push;
            if (push) begin
                out_data_d = sel_data;
                out_chan_d = grant_idx;
                ptr_d      = (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;

endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: an 8-channel and a 6-channel instance share
// clock and reset; each task drives one scenario and checks its own results.
module tb_arb_mux;
    import mux_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    arb_mux_if #(.WIDTH(8), .CHANNELS(8)) bus8 ();
    arb_mux_if #(.WIDTH(8), .CHANNELS(6)) bus6 ();

    arb_mux #(.WIDTH(8), .CHANNELS(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    arb_mux #(.WIDTH(8), .CHANNELS(6)) dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus6.slave)
    );

    task automatic load_data();
        for (int i = 0; i < 8; i++) bus8.in_data[i*8 +: 8] = 8'(10 + 10*i);
        for (int i = 0; i < 6; i++) bus6.in_data[i*8 +: 8] = 8'(10 + 10*i);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        load_data();
        rst_n          = 1'b0;
        bus8.in_valid  = 8'hFF;
        bus6.in_valid  = 6'h3F;
        bus8.mode      = MODE_ROUND_ROBIN;
        bus6.mode      = MODE_ROUND_ROBIN;
        bus8.slct      = 3'd0;
        bus6.slct      = 3'd0;
        bus8.out_ready = 1'b1;
        bus6.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus8.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", bus8.out_valid); end
        n_checks++; if (bus8.out_data !== 8'd0) begin n_fail++; $display("FAIL reset_out_data got %0d want 0", bus8.out_data); end
        n_checks++; if (bus8.out_chan !== 3'd0) begin n_fail++; $display("FAIL reset_out_chan got %0d want 0", bus8.out_chan); end
        n_checks++; if (bus8.in_ready !== 8'h00) begin n_fail++; $display("FAIL reset_in_ready8 got %h want 00", bus8.in_ready); end
        n_checks++; if (bus6.in_ready !== 6'h00) begin n_fail++; $display("FAIL reset_in_ready6 got %h want 00", bus6.in_ready); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (bus8.in_ready !== 8'h01) begin n_fail++; $display("FAIL post_reset_in_ready got %h want 01", bus8.in_ready); end
        @(posedge clk); #1;
        n_checks++; if (bus8.out_valid !== 1'b1) begin n_fail++; $display("FAIL post_reset_valid got %0b want 1", bus8.out_valid); end
        n_checks++; if (bus8.out_chan !== 3'd0) begin n_fail++; $display("FAIL post_reset_chan got %0d want 0", bus8.out_chan); end
        n_checks++; if (bus8.out_data !== 8'd10) begin n_fail++; $display("FAIL post_reset_data got %0d want 10", bus8.out_data); end
    endtask

    task automatic test_fixed_sweep();
        do_reset();
        bus8.mode     = MODE_FIXED;
        bus8.in_valid = 8'hFF;
        for (int s = 0; s < 8; s++) begin
            bus8.slct = 3'(s);
            @(posedge clk); #1;
            n_checks++; if (bus8.out_valid !== 1'b1) begin n_fail++; $display("FAIL fixed_valid s=%0d got %0b want 1", s, bus8.out_valid); end
            n_checks++; if (bus8.out_data !== 8'(10 + 10*s)) begin n_fail++; $display("FAIL fixed_data s=%0d got %0d want %0d", s, bus8.out_data, 10 + 10*s); end
            n_checks++; if (bus8.out_chan !== 3'(s)) begin n_fail++; $display("FAIL fixed_chan s=%0d got %0d want %0d", s, bus8.out_chan, s); end
        end
    endtask

    task automatic test_fixed_invalid();
        do_reset();
        bus8.mode     = MODE_FIXED;
        bus6.mode     = MODE_FIXED;
        bus8.in_valid = 8'hFF;
        bus6.in_valid = 6'h3F;
        bus8.slct     = 3'd2;
        bus6.slct     = 3'd2;
        @(posedge clk); #1;
        n_checks++; if (bus6.out_valid !== 1'b1 || bus6.out_chan !== 3'd2) begin n_fail++; $display("FAIL fixed6_load got v=%0b c=%0d want v=1 c=2", bus6.out_valid, bus6.out_chan); end
        bus6.slct     = 3'd7;
        bus8.in_valid = 8'hFB;
        #1;
        n_checks++; if (bus6.in_ready !== 6'h00) begin n_fail++; $display("FAIL oor_in_ready got %h want 00", bus6.in_ready); end
        n_checks++; if (bus8.in_ready !== 8'h00) begin n_fail++; $display("FAIL novalid_in_ready got %h want 00", bus8.in_ready); end
        @(posedge clk); #1;
        n_checks++; if (bus6.out_valid !== 1'b0) begin n_fail++; $display("FAIL oor_out_valid got %0b want 0", bus6.out_valid); end
        n_checks++; if (bus6.out_data !== 8'd30) begin n_fail++; $display("FAIL oor_data_hold got %0d want 30", bus6.out_data); end
        n_checks++; if (bus8.out_valid !== 1'b0) begin n_fail++; $display("FAIL novalid_out_valid got %0b want 0", bus8.out_valid); end
        n_checks++; if (bus8.out_chan !== 3'd2) begin n_fail++; $display("FAIL novalid_chan_hold got %0d want 2", bus8.out_chan); end
        bus8.in_valid = 8'hFF;
        bus6.slct     = 3'd0;
    endtask

    task automatic test_rr_fair();
        do_reset();
        bus8.mode      = MODE_ROUND_ROBIN;
        bus8.in_valid  = 8'hFF;
        bus8.out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            n_checks++; if (bus8.out_chan !== 3'(k % 8) || bus8.out_valid !== 1'b1) begin n_fail++; $display("FAIL rr_chan k=%0d got %0d want %0d", k, bus8.out_chan, k % 8); end
            n_checks++; if (bus8.out_data !== 8'(10 + 10*(k % 8))) begin n_fail++; $display("FAIL rr_data k=%0d got %0d want %0d", k, bus8.out_data, 10 + 10*(k % 8)); end
        end
    endtask

    task automatic test_rr_sparse();
        int exp_seq [4];
        exp_seq = '{3, 5, 3, 5};
        do_reset();
        bus8.mode     = MODE_ROUND_ROBIN;
        bus8.in_valid = 8'h28;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            n_checks++; if (bus8.out_chan !== 3'(exp_seq[k])) begin n_fail++; $display("FAIL rr_sparse k=%0d got %0d want %0d", k, bus8.out_chan, exp_seq[k]); end
        end
        bus8.in_valid = 8'hFF;
    endtask

    task automatic test_backpressure();
        do_reset();
        bus8.mode      = MODE_ROUND_ROBIN;
        bus8.in_valid  = 8'hFF;
        bus8.out_ready = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (bus8.out_valid !== 1'b1 || bus8.out_chan !== 3'd0) begin n_fail++; $display("FAIL bp_load got v=%0b c=%0d want v=1 c=0", bus8.out_valid, bus8.out_chan); end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            n_checks++; if (bus8.out_data !== 8'd10 || bus8.out_chan !== 3'd0) begin n_fail++; $display("FAIL bp_hold k=%0d got d=%0d c=%0d want d=10 c=0", k, bus8.out_data, bus8.out_chan); end
            n_checks++; if (bus8.in_ready !== 8'h00) begin n_fail++; $display("FAIL bp_in_ready k=%0d got %h want 00", k, bus8.in_ready); end
        end
        bus8.out_ready = 1'b1;
        #1;
        n_checks++; if (bus8.in_ready !== 8'h02) begin n_fail++; $display("FAIL bp_passthru got %h want 02", bus8.in_ready); end
        @(posedge clk); #1;
        n_checks++; if (bus8.out_valid !== 1'b1 || bus8.out_data !== 8'd20 || bus8.out_chan !== 3'd1) begin n_fail++; $display("FAIL bp_nobubble got v=%0b d=%0d c=%0d want v=1 d=20 c=1", bus8.out_valid, bus8.out_data, bus8.out_chan); end
        @(posedge clk); #1;
        n_checks++; if (bus8.out_chan !== 3'd2) begin n_fail++; $display("FAIL bp_next got %0d want 2", bus8.out_chan); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        bus8.mode      = MODE_ROUND_ROBIN;
        bus8.in_valid  = 8'hFF;
        bus8.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus8.out_ready = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (bus8.out_valid !== 1'b1 || bus8.out_chan !== 3'd2) begin n_fail++; $display("FAIL mid_held got v=%0b c=%0d want v=1 c=2", bus8.out_valid, bus8.out_chan); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (bus8.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %0b want 0", bus8.out_valid); end
        n_checks++; if (bus8.out_data !== 8'd0) begin n_fail++; $display("FAIL mid_data got %0d want 0", bus8.out_data); end
        rst_n          = 1'b1;
        bus8.out_ready = 1'b1;
        #1;
        n_checks++; if (bus8.in_ready !== 8'h01) begin n_fail++; $display("FAIL mid_ptr got %h want 01", bus8.in_ready); end
        @(posedge clk); #1;
        n_checks++; if (bus8.out_chan !== 3'd0) begin n_fail++; $display("FAIL mid_first got %0d want 0", bus8.out_chan); end
    endtask

    initial begin
        test_reset();
        test_fixed_sweep();
        test_fixed_invalid();
        test_rr_fair();
        test_rr_sparse();
        test_backpressure();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arb_mux.md
# arb_mux

Parametrised N-channel, W-bit multiplexer with per-channel valid/ready handshakes, a runtime-selectable arbitration mode, and a registered output stage. It generalises the combinational 8-way select into a flow-controlled merge point. It sits in front of the shared 8-bit bus or ALU operand port, where several producers compete for one consumer. Transfers are lossless and the output stage sustains one word per cycle.

## Interface

- WIDTH, 8, data width of every channel and of the output
- CHANNELS, 8, number of input channels (2..16, need not be a power of two)
- SEL_W, $clog2(CHANNELS), width of slct and out_chan (derived; do not override)

- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset, sampled on rising edge of clk
- in_data  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  CHANNELS  channel i offers a word
- in_ready  out  CHANNELS  channel i word accepted this cycle when in_valid[i] & in_ready[i]
- mode  in  1  0 = FIXED (slct chooses channel), 1 = ROUND_ROBIN
- slct  in  SEL_W  channel index used in FIXED mode
- out_data  out  WIDTH  registered selected word
- out_chan  out  SEL_W  index of the channel that supplied out_data
- out_valid  out  1  out_data/out_chan hold a word
- out_ready  in  1  consumer accepts the word when out_valid & out_ready

## Operation

- Output register (one entry) is free when out_valid=0 or out_ready=1 (pop this cycle). It is loaded only when free.
- Grant selection is combinational, with at most one grant bit set:
  - FIXED: grant = onehot(slct) & in_valid. If slct >= CHANNELS, grant = 0.
  - ROUND_ROBIN: scan channels ptr, ptr+1, … wrapping modulo CHANNELS. The grant goes to the first channel with in_valid set.
- in_ready = grant & {CHANNELS{free}}. in_ready never asserts for a channel with in_valid=0.
- On a transfer from channel k: out_data <= channel k data, out_chan <= k, out_valid <= 1.
- ptr <= (k == CHANNELS-1) ? 0 : k+1, in either mode. ptr is unchanged on cycles with no input transfer.
- When free with no grant: out_valid <= 0 if popping. out_data and out_chan hold their last values.
- mode and slct are sampled every cycle; a mode change takes effect on the same cycle. ptr is retained across mode changes.
- Reset values: out_valid=0, out_data=0, out_chan=0, ptr=0. in_ready is 0 during reset.
- Reset while a word is held discards it; no pop is reported.

## Timing

- Latency: input accept at edge N gives out_valid at N+1, with data present in the cycle after the accepting edge.
- Throughput: one word per cycle while out_ready=1.
- out_ready → in_ready is a combinational path (pass-through ready). There are no other combinational input-to-output paths; out_* are registered.
- Simultaneous pop and push: both occur at the same edge, and the new word replaces the old one with no bubble.
- Backpressure: with out_ready=0 and out_valid=1, all in_ready=0 and out_data/out_chan stay stable.
- Round-robin fairness: with all channels continuously valid and out_ready=1, each channel is granted exactly once in every CHANNELS consecutive transfers.

## Structure

- Shared package mux_pkg holds:
  - MODE_FIXED=1'b0 and MODE_ROUND_ROBIN=1'b1
  - a function sel_width(n) returning the select width for n channels
- Sub-module rr_arbiter (CHANNELS):
  - inputs: req, ptr, enable
  - outputs: one-hot grant and encoded index
  - contains the wrap-around priority scan
- arb_mux contains the FIXED decode, the ptr register, and the output register.

## Test plan

- Reset: hold rst_n=0 for 2 cycles with all in_valid=1 → out_valid=0, out_data=0, out_chan=0, in_ready=0. After release, the first grant goes to channel 0 in ROUND_ROBIN.
- FIXED sweep:
  - Setup: WIDTH=8, CHANNELS=8, data_i=10+10*i, all valid, out_ready=1.
  - Stimulus: step slct 0..7.
  - Required: out_data = 10, 20, … 80 one cycle after each step, with out_chan matching slct.
- FIXED, invalid or out-of-range select:
  - CHANNELS=6 with slct=7 → in_ready=0 and out_valid drops to 0.
  - slct=2 with in_valid[2]=0 → no transfer.
- ROUND_ROBIN fairness and ptr:
  - All channels valid for 16 cycles → out_chan sequence is 0..7, 0..7.
  - Only channels 3 and 5 valid, starting from ptr=0 → sequence is 3, 5, 3, 5.
- Backpressure:
  - Hold out_ready=0 for 4 cycles with a word held → out_data stable and in_ready all 0.
  - Raise out_ready → a pop and a new push occur at the same edge, with no bubble.
- Reset mid-stream: assert rst_n=0 while out_valid=1 and out_ready=0 → out_valid=0 next cycle and ptr returns to 0.
